// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// The LEN5_TRAP_VECTORED_EN macro (see trap_ctrl.sv) does not affect this file.
package trap_ctrl_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE,
        REDIR
    } trap_state_t;

    typedef enum logic [1:0] {
        DIRECT   = 2'b00,
        VECTORED = 2'b01
    } mtvec_mode_t;

    localparam int unsigned INT_CODE_MEI = 11;
    localparam int unsigned INT_CODE_MSI = 3;
    localparam int unsigned INT_CODE_MTI = 7;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    localparam logic [1:0] PRIV_MODE_M = 2'b11;

endpackage

// File: rtl/trap_ctrl_int_arbiter.sv
// trap_int_arbiter: fixed-priority encoder over enabled pending interrupts
// (MEI > MSI > MTI), producing an mcause value with the interrupt bit set.
module trap_int_arbiter
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] mip_i,
    input  logic [XLEN-1:0] mie_i,
    output logic            valid_o,
    output logic [XLEN-1:0] cause_o
);

    logic [XLEN-1:0] pend;
    logic            unused_pend;

    assign pend        = mip_i & mie_i;
    assign unused_pend = ^pend;

    always_comb begin
        valid_o = 1'b0;
        cause_o = '0;
        if (pend[INT_CODE_MEI]) begin
            valid_o = 1'b1;
            cause_o = {1'b1, (XLEN-1)'(INT_CODE_MEI)};
        end else if (pend[INT_CODE_MSI]) begin
            valid_o = 1'b1;
            cause_o = {1'b1, (XLEN-1)'(INT_CODE_MSI)};
        end else if (pend[INT_CODE_MTI]) begin
            valid_o = 1'b1;
            cause_o = {1'b1, (XLEN-1)'(INT_CODE_MTI)};
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer driving CSR write strobes and PC redirect.
// Optional LEN5_TRAP_VECTORED_EN: vectored interrupt targets when mtvec.mode == 2'b01.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter logic        TVAL_ZERO = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            except_valid_i,
    input  logic [XLEN-1:0] except_cause_i,
    input  logic [XLEN-1:0] except_pc_i,
    input  logic [XLEN-1:0] except_tval_i,
    input  logic            mret_valid_i,
    input  logic            int_boundary_i,
    input  logic [XLEN-1:0] next_pc_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mip_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_we_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            trap_taken_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    trap_state_t     state;
    logic [XLEN-1:0] target_q;
    logic            arb_valid;
    logic [XLEN-1:0] arb_cause;
    logic            int_req;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] int_target;

    trap_int_arbiter #(.XLEN(XLEN)) u_int_arb (
        .mip_i   (mip_i),
        .mie_i   (mie_i),
        .valid_o (arb_valid),
        .cause_o (arb_cause)
    );

    assign int_req    = mstatus_i[MSTATUS_MIE] && int_boundary_i && arb_valid;
    assign mtvec_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef LEN5_TRAP_VECTORED_EN
    assign int_target = (mtvec_mode_t'(mtvec_i[1:0]) == VECTORED)
                      ? mtvec_base + {arb_cause[XLEN-3:0], 2'b00}
                      : mtvec_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_i[1:0];
    assign int_target        = mtvec_base;
`endif

    function automatic logic [XLEN-1:0] save_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                       = s;
        r[MSTATUS_MPIE]         = s[MSTATUS_MIE];
        r[MSTATUS_MIE]          = 1'b0;
        r[MSTATUS_MPP_LO +: 2]  = PRIV_MODE_M;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] restore_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                       = s;
        r[MSTATUS_MIE]          = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE]         = 1'b1;
        r[MSTATUS_MPP_LO +: 2]  = PRIV_MODE_M;
        return r;
    endfunction

    // CSR write values are registered at accept so csr_we_o is high exactly during SAVE/RESTORE;
    // mcause_o/mtval_o keep their last trap value across MRET (no mcause/mtval read ports).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            req_ready_o      <= 1'b1;
            csr_we_o         <= 1'b0;
            mepc_o           <= '0;
            mcause_o         <= '0;
            mtval_o          <= '0;
            mstatus_o        <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            trap_taken_o     <= 1'b0;
            target_q         <= '0;
        end else begin
            csr_we_o     <= 1'b0;
            trap_taken_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (except_valid_i) begin
                        state       <= SAVE;
                        req_ready_o <= 1'b0;
                        csr_we_o    <= 1'b1;
                        mepc_o      <= except_pc_i & ALIGN_MASK;
                        mcause_o    <= except_cause_i;
                        mtval_o     <= TVAL_ZERO ? '0 : except_tval_i;
                        mstatus_o   <= save_mstatus(mstatus_i);
                        target_q    <= mtvec_base;
                    end else if (mret_valid_i) begin
                        state       <= RESTORE;
                        req_ready_o <= 1'b0;
                        csr_we_o    <= 1'b1;
                        mepc_o      <= mepc_i;
                        mstatus_o   <= restore_mstatus(mstatus_i);
                        target_q    <= mepc_i & ALIGN_MASK;
                    end else if (int_req) begin
                        state       <= SAVE;
                        req_ready_o <= 1'b0;
                        csr_we_o    <= 1'b1;
                        mepc_o      <= next_pc_i & ALIGN_MASK;
                        mcause_o    <= arb_cause;
                        mtval_o     <= '0;
                        mstatus_o   <= save_mstatus(mstatus_i);
                        target_q    <= int_target;
                    end
                end
                SAVE, RESTORE: begin
                    state            <= REDIR;
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= target_q;
                end
                REDIR: begin
                    if (redirect_ready_i) begin
                        state            <= IDLE;
                        redirect_valid_o <= 1'b0;
                        trap_taken_o     <= 1'b1;
                        req_ready_o      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven and randomized checks of trap_ctrl against a reference model.
// Honours LEN5_TRAP_VECTORED_EN to pick the expected interrupt targets.
module tb_trap_ctrl;

`ifdef LEN5_TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif
    localparam logic [63:0] INTR = 64'h8000_0000_0000_0000;

    typedef struct {
        bit          ev, mv, ib, hold;
        logic [63:0] cause, pc, tval, npc, mstatus, mip, mie, mtvec, mepc;
        int          delay;
    } stim_t;

    // kind: 0 = no request taken, 1 = trap entry, 2 = MRET
    typedef struct {
        int          kind;
        logic [63:0] mepc, mcause, mtval, mstatus, target;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        except_valid_i, mret_valid_i, int_boundary_i, redirect_ready_i;
    logic [63:0] except_cause_i, except_pc_i, except_tval_i, next_pc_i;
    logic [63:0] mstatus_i, mip_i, mie_i, mtvec_i, mepc_i;
    logic        req_ready_o, csr_we_o, redirect_valid_o, trap_taken_o;
    logic [63:0] mepc_o, mcause_o, mtval_o, mstatus_o, redirect_pc_o;

    int total = 0;
    int bad   = 0;

    trap_ctrl #(.XLEN(64), .TVAL_ZERO(1'b0)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .except_valid_i   (except_valid_i),
        .except_cause_i   (except_cause_i),
        .except_pc_i      (except_pc_i),
        .except_tval_i    (except_tval_i),
        .mret_valid_i     (mret_valid_i),
        .int_boundary_i   (int_boundary_i),
        .next_pc_i        (next_pc_i),
        .req_ready_o      (req_ready_o),
        .mstatus_i        (mstatus_i),
        .mip_i            (mip_i),
        .mie_i            (mie_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .csr_we_o         (csr_we_o),
        .mepc_o           (mepc_o),
        .mcause_o         (mcause_o),
        .mtval_o          (mtval_o),
        .mstatus_o        (mstatus_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .trap_taken_o     (trap_taken_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic stim_t stim_exc(logic [63:0] cause, logic [63:0] pc, logic [63:0] tval,
                                       logic [63:0] mstatus, logic [63:0] mtvec, int delay);
        stim_t s;
        s = '{ev: 1'b1, mv: 1'b0, ib: 1'b0, hold: 1'b0, cause: cause, pc: pc, tval: tval,
              npc: 64'h0, mstatus: mstatus, mip: 64'h0, mie: 64'h0, mtvec: mtvec,
              mepc: 64'h0, delay: delay};
        return s;
    endfunction

    function automatic stim_t stim_int(logic [63:0] npc, logic [63:0] bits, logic [63:0] mstatus,
                                       logic [63:0] mtvec, int delay);
        stim_t s;
        s = '{ev: 1'b0, mv: 1'b0, ib: 1'b1, hold: 1'b0, cause: 64'h0, pc: 64'h0, tval: 64'h0,
              npc: npc, mstatus: mstatus, mip: bits, mie: bits, mtvec: mtvec,
              mepc: 64'h0, delay: delay};
        return s;
    endfunction

    function automatic stim_t stim_mret(logic [63:0] mepc, logic [63:0] mstatus, int delay);
        stim_t s;
        s = '{ev: 1'b0, mv: 1'b1, ib: 1'b0, hold: 1'b0, cause: 64'h0, pc: 64'h0, tval: 64'h0,
              npc: 64'h0, mstatus: mstatus, mip: 64'h0, mie: 64'h0, mtvec: 64'h0,
              mepc: mepc, delay: delay};
        return s;
    endfunction

    function automatic exp_t expv(int kind, logic [63:0] mepc, logic [63:0] mcause,
                                  logic [63:0] mtval, logic [63:0] mstatus, logic [63:0] target);
        exp_t e;
        e = '{kind: kind, mepc: mepc, mcause: mcause, mtval: mtval, mstatus: mstatus,
              target: target};
        return e;
    endfunction

    // Reference model: architectural trap-entry / MRET rules, arithmetic on whole values.
    function automatic exp_t model(stim_t s);
        exp_t        e;
        logic [63:0] pend, ms;
        int unsigned prio[3];
        int unsigned code;
        bit          found;
        prio  = '{11, 3, 7};
        pend  = s.mip & s.mie;
        found = 1'b0;
        code  = 0;
        for (int i = 0; i < 3; i++) begin
            if (!found && pend[prio[i]]) begin
                found = 1'b1;
                code  = prio[i];
            end
        end
        e = expv(0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        if (s.ev || (!s.mv && s.mstatus[3] && s.ib && found)) begin
            ms = s.mstatus;
            ms[7] = s.mstatus[3];
            ms[3] = 1'b0;
            ms[12:11] = 2'b11;
            e.kind    = 1;
            e.mstatus = ms;
            e.target  = s.mtvec - (s.mtvec % 4);
            if (s.ev) begin
                e.mepc   = s.pc - (s.pc % 4);
                e.mcause = s.cause;
                e.mtval  = s.tval;
            end else begin
                e.mepc   = s.npc - (s.npc % 4);
                e.mcause = INTR + 64'(code);
                e.mtval  = 64'h0;
                if (VEC && (s.mtvec % 4) == 1)
                    e.target = e.target + 64'(4 * code);
            end
        end else if (s.mv) begin
            ms = s.mstatus;
            ms[3] = s.mstatus[7];
            ms[7] = 1'b1;
            ms[12:11] = 2'b11;
            e.kind    = 2;
            e.mepc    = s.mepc;
            e.mstatus = ms;
            e.target  = s.mepc - (s.mepc % 4);
        end
        return e;
    endfunction

    task automatic apply(input stim_t s);
        except_valid_i = s.ev;
        mret_valid_i   = s.mv;
        int_boundary_i = s.ib;
        except_cause_i = s.cause;
        except_pc_i    = s.pc;
        except_tval_i  = s.tval;
        next_pc_i      = s.npc;
        mstatus_i      = s.mstatus;
        mip_i          = s.mip;
        mie_i          = s.mie;
        mtvec_i        = s.mtvec;
        mepc_i         = s.mepc;
    endtask

    task automatic clear_req(input bit hold);
        except_valid_i = 1'b0;
        mret_valid_i   = 1'b0;
        if (!hold) begin
            int_boundary_i = 1'b0;
            mip_i          = 64'h0;
            mie_i          = 64'h0;
        end
    endtask

    // Called at posedge+#1 while the DUT is idle; returns at posedge+#1 of the trap_taken cycle.
    task automatic run_trap(input string tag, input stim_t s, input exp_t e);
        apply(s);
        @(posedge clk); #1;
        chk({tag, "_pulse_single"}, 64'(trap_taken_o), 64'd0);
        if (e.kind == 0) begin
            chk({tag, "_noreq_we"}, 64'(csr_we_o), 64'd0);
            chk({tag, "_noreq_ready"}, 64'(req_ready_o), 64'd1);
            clear_req(1'b0);
            return;
        end
        chk({tag, "_ready_low"}, 64'(req_ready_o), 64'd0);
        chk({tag, "_we"}, 64'(csr_we_o), 64'd1);
        chk({tag, "_mepc"}, mepc_o, e.mepc);
        chk({tag, "_mstatus"}, mstatus_o, e.mstatus);
        if (e.kind == 1) begin
            chk({tag, "_mcause"}, mcause_o, e.mcause);
            chk({tag, "_mtval"}, mtval_o, e.mtval);
        end
        chk({tag, "_no_early_redir"}, 64'(redirect_valid_o), 64'd0);
        clear_req(s.hold);
        @(posedge clk); #1;
        chk({tag, "_we_drop"}, 64'(csr_we_o), 64'd0);
        chk({tag, "_redir_valid"}, 64'(redirect_valid_o), 64'd1);
        chk({tag, "_redir_pc"}, redirect_pc_o, e.target);
        for (int i = 0; i < s.delay; i++) begin
            @(posedge clk); #1;
            chk({tag, "_bp_valid"}, 64'(redirect_valid_o), 64'd1);
            chk({tag, "_bp_pc"}, redirect_pc_o, e.target);
            chk({tag, "_bp_ready"}, 64'(req_ready_o), 64'd0);
            chk({tag, "_bp_taken"}, 64'(trap_taken_o), 64'd0);
        end
        redirect_ready_i = 1'b1;
        @(posedge clk); #1;
        redirect_ready_i = 1'b0;
        chk({tag, "_taken"}, 64'(trap_taken_o), 64'd1);
        chk({tag, "_redir_drop"}, 64'(redirect_valid_o), 64'd0);
        chk({tag, "_ready_back"}, 64'(req_ready_o), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_we"}, 64'(csr_we_o), 64'd0);
        chk({tag, "_mepc"}, mepc_o, 64'h0);
        chk({tag, "_mcause"}, mcause_o, 64'h0);
        chk({tag, "_mtval"}, mtval_o, 64'h0);
        chk({tag, "_mstatus"}, mstatus_o, 64'h0);
        chk({tag, "_redir_valid"}, 64'(redirect_valid_o), 64'd0);
        chk({tag, "_redir_pc"}, redirect_pc_o, 64'h0);
        chk({tag, "_taken"}, 64'(trap_taken_o), 64'd0);
    endtask

    vec_t tbl[13];

    initial begin
        stim_t s;
        exp_t  e;

        tbl[0]  = '{stim_exc(64'd2, 64'h1000, 64'hdead, 64'h8, 64'h8000, 0),
                    expv(1, 64'h1000, 64'd2, 64'hdead, 64'h1880, 64'h8000)};
        tbl[1]  = '{stim_int(64'h2004, 64'h80, 64'h8, 64'h8001, 1),
                    expv(1, 64'h2004, INTR | 64'd7, 64'h0, 64'h1880,
                         VEC ? 64'h801C : 64'h8000)};
        tbl[2]  = '{stim_mret(64'h3000, 64'h80, 5),
                    expv(2, 64'h3000, 64'h0, 64'h0, 64'h1888, 64'h3000)};
        tbl[3]  = '{stim_exc(64'd0, 64'h1003, 64'h1003, 64'h0, 64'h4002, 2),
                    expv(1, 64'h1000, 64'd0, 64'h1003, 64'h1800, 64'h4000)};
        tbl[4]  = '{stim_int(64'h6000, 64'h888, 64'h8, 64'h100, 0),
                    expv(1, 64'h6000, INTR | 64'd11, 64'h0, 64'h1880, 64'h100)};
        tbl[5]  = '{stim_int(64'h7002, 64'h088, 64'h8, 64'h8001, 0),
                    expv(1, 64'h7000, INTR | 64'd3, 64'h0, 64'h1880,
                         VEC ? 64'h800C : 64'h8000)};
        tbl[6]  = '{stim_int(64'h10, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 0),
                    expv(1, 64'h10, INTR | 64'd11, 64'h0, 64'hFFFF_FFFF_FFFF_FFF7,
                         VEC ? 64'h1C : 64'hFFFF_FFFF_FFFF_FFF0)};
        tbl[7]  = '{stim_int(64'h20, 64'h800, 64'h0, 64'h100, 0),
                    expv(0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0)};
        s = stim_int(64'h20, 64'h800, 64'h8, 64'h100, 0);
        s.ib = 1'b0;
        tbl[8]  = '{s, expv(0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0)};
        s = stim_exc(64'd5, 64'h1100, 64'h77, 64'h8, 64'h9000, 0);
        s.mv = 1'b1; s.ib = 1'b1; s.mip = 64'h800; s.mie = 64'h800; s.hold = 1'b1;
        tbl[9]  = '{s, expv(1, 64'h1100, 64'd5, 64'h77, 64'h1880, 64'h9000)};
        tbl[10] = '{stim_int(64'h5000, 64'h800, 64'h8, 64'h9001, 0),
                    expv(1, 64'h5000, INTR | 64'd11, 64'h0, 64'h1880,
                         VEC ? 64'h902C : 64'h9000)};
        tbl[11] = '{stim_mret(64'h3006, 64'h8, 0),
                    expv(2, 64'h3006, 64'h0, 64'h0, 64'h1880, 64'h3004)};
        s = stim_mret(64'h4000, 64'h88, 0);
        s.ib = 1'b1; s.mip = 64'h80; s.mie = 64'h80;
        tbl[12] = '{s, expv(2, 64'h4000, 64'h0, 64'h0, 64'h1888, 64'h4000)};

        rst_i = 1'b1;
        redirect_ready_i = 1'b0;
        apply(stim_mret(64'h0, 64'h0, 0));
        mret_valid_i = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 64'(req_ready_o), 64'd1);

        foreach (tbl[i]) begin
            run_trap($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
        end

        // asynchronous reset while the CSR strobe is active
        apply(stim_exc(64'd2, 64'h1000, 64'hdead, 64'h8, 64'h8000, 0));
        @(posedge clk); #1;
        chk("rst_pre_we", 64'(csr_we_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        clear_req(1'b0);
        @(posedge clk); #1;
        chk_reset_outputs("rst_edge");
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_redir", 64'(redirect_valid_o), 64'd0);
            chk("rst_no_we", 64'(csr_we_o), 64'd0);
        end

        for (int n = 0; n < 60; n++) begin
            s.ev      = ($urandom_range(0, 3) == 0);
            s.mv      = ($urandom_range(0, 3) == 0);
            s.ib      = 1'($urandom_range(0, 1));
            s.hold    = 1'b0;
            s.cause   = 64'($urandom_range(0, 15));
            s.pc      = {$urandom, $urandom};
            s.tval    = {$urandom, $urandom};
            s.npc     = {$urandom, $urandom};
            s.mstatus = {$urandom, $urandom};
            s.mip     = 64'($urandom_range(0, 16'hFFFF));
            s.mie     = 64'($urandom_range(0, 16'hFFFF));
            s.mtvec   = {$urandom, $urandom};
            s.mepc    = {$urandom, $urandom};
            s.delay   = int'($urandom_range(0, 3));
            e = model(s);
            run_trap($sformatf("rnd%0d", n), s, e);
        end

        @(posedge clk); #1;
        chk("final_pulse_single", 64'(trap_taken_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
